// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: parity modes, RX FSM encoding, baud divider helper
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int os_div_calc(input int clock_freq, input int baudrate, input int oversample);
        return (clock_freq + (baudrate * oversample) / 2) / (baudrate * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - received-character bundle from the UART receiver to command/FIFO logic
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;

    modport master (output data_out, rx_valid, parity_err, frame_err, break_det);
    modport slave  (input  data_out, rx_valid, parity_err, frame_err, break_det);
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample prescaler: one-clock tick every OS_DIV enabled clocks
module uart_baud_tick #(
    parameter int OS_DIV = 15
) (
    input  logic clock,
    input  logic n_reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int W = $clog2(OS_DIV + 1);
    localparam logic [W-1:0] LAST = W'(OS_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = enable && !clear && (cnt == LAST);
endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with 3-sample majority vote,
// configurable frame format and parity/framing/break reporting
module uart_rx_os import uart_pkg::*; #(
    parameter int CLOCK_FREQ = 27000000,
    parameter int BAUDRATE   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int OS_DIV     = os_div_calc(CLOCK_FREQ, BAUDRATE, OVERSAMPLE)
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         rx,
    uart_rx_os_if.master rx_if
);
    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int HCW = $clog2(OS_DIV + 1);
    localparam int BIW = $clog2(DATA_BITS);
    localparam int M   = OVERSAMPLE / 2;
    localparam logic [TCW-1:0] T_S0   = TCW'(M - 1);
    localparam logic [TCW-1:0] T_S1   = TCW'(M);
    localparam logic [TCW-1:0] T_VOTE = TCW'(M + 1);
    localparam logic [TCW-1:0] T_END  = TCW'(OVERSAMPLE - 1);
    localparam logic [BIW-1:0] LAST_BIT = BIW'(DATA_BITS - 1);
    localparam logic [HCW-1:0] ARM_CNT  = HCW'(OS_DIV);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_os: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_oversample
        $error("uart_rx_os: OVERSAMPLE must be 8 or 16");
    end
    if (OS_DIV < 1) begin : g_bad_os_div
        $error("uart_rx_os: OS_DIV must be >= 1");
    end

    rx_state_t            state, next_state;
    logic                 rx_meta, rx_s;
    logic [HCW-1:0]       hi_cnt;
    logic                 armed, start_cond;
    logic                 presc_clear, presc_en, tick;
    logic [TCW-1:0]       tick_cnt;
    logic                 samp0, samp1, vote_bit, vote_now, end_bit;
    logic [DATA_BITS-1:0] shift;
    logic [BIW-1:0]       bit_idx;
    logic                 stop_idx, last_stop, load_out;
    logic                 par_c, frm_c, brk_c, par_bad;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Counts consecutive high clocks on rx_s; a start edge is only accepted
    // once the line has idled high for a full tick, so a held break cannot re-trigger.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            hi_cnt <= '0;
        end else if (!rx_s) begin
            hi_cnt <= '0;
        end else if (!armed) begin
            hi_cnt <= hi_cnt + HCW'(1);
        end
    end

    assign armed      = (hi_cnt == ARM_CNT);
    assign start_cond = armed && !rx_s;

    uart_baud_tick #(.OS_DIV(OS_DIV)) u_baud_tick (
        .clock   (clock),
        .n_reset (n_reset),
        .clear   (presc_clear),
        .enable  (presc_en),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            tick_cnt <= '0;
        end else if (presc_clear) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + TCW'(1);
        end
    end

    assign vote_now  = tick && (tick_cnt == T_VOTE);
    assign end_bit   = tick && (tick_cnt == T_END);
    assign vote_bit  = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
    assign last_stop = (STOP_BITS == 1) || stop_idx;
    assign par_bad   = (PARITY == PAR_ODD) ? ~((^shift) ^ vote_bit) : ((^shift) ^ vote_bit);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_cond) next_state = ST_START;
            end
            ST_START: begin
                if (vote_now && vote_bit) next_state = ST_IDLE;
                else if (end_bit)         next_state = ST_DATA;
            end
            ST_DATA: begin
                if (end_bit && bit_idx == LAST_BIT)
                    next_state = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: begin
                if (end_bit) next_state = ST_STOP;
            end
            ST_STOP: begin
                if (vote_now && last_stop) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = start_cond ? ST_START : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_clear = (state == ST_IDLE) || (state == ST_DONE);
        presc_en    = !presc_clear;
        load_out    = (state == ST_STOP) && vote_now && last_stop;
    end

    // Outputs load on the final stop vote so they are valid alongside rx_valid in DONE.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            samp0            <= 1'b1;
            samp1            <= 1'b1;
            shift            <= '0;
            bit_idx          <= '0;
            stop_idx         <= 1'b0;
            par_c            <= 1'b0;
            frm_c            <= 1'b0;
            brk_c            <= 1'b0;
            rx_if.data_out   <= '0;
            rx_if.rx_valid   <= 1'b0;
            rx_if.parity_err <= 1'b0;
            rx_if.frame_err  <= 1'b0;
            rx_if.break_det  <= 1'b0;
        end else begin
            rx_if.rx_valid <= load_out;
            if (tick && tick_cnt == T_S0) samp0 <= rx_s;
            if (tick && tick_cnt == T_S1) samp1 <= rx_s;
            case (state)
                ST_START: begin
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_c    <= 1'b0;
                    frm_c    <= 1'b0;
                    brk_c    <= 1'b1;
                end
                ST_DATA: begin
                    if (vote_now) begin
                        shift <= {vote_bit, shift[DATA_BITS-1:1]};
                        if (vote_bit) brk_c <= 1'b0;
                    end
                    if (end_bit && bit_idx != LAST_BIT) bit_idx <= bit_idx + BIW'(1);
                end
                ST_PARITY: begin
                    if (vote_now) begin
                        par_c <= par_bad;
                        if (vote_bit) brk_c <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (vote_now && !vote_bit) frm_c <= 1'b1;
                    if (vote_now && vote_bit && !stop_idx) brk_c <= 1'b0;
                    if (end_bit) stop_idx <= 1'b1;
                end
                default: ;
            endcase
            if (load_out) begin
                rx_if.data_out   <= shift;
                rx_if.parity_err <= par_c;
                rx_if.frame_err  <= frm_c | ~vote_bit;
                rx_if.break_det  <= brk_c & (stop_idx | ~vote_bit);
            end
        end
    end
endmodule
